// File: rtl/mem_stage_module.sv
// mem_stage_module: MEM pipeline stage with a single-outstanding data-memory
// handshake (IDLE -> ACCESS -> DONE) and the MEM/WB pipeline register.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, an access that
// sees no mem_ready for TIMEOUT_CYCLES cycles is aborted with 32'hDEADBEEF and
// the sticky mem_err flag is set. When it is undefined, ACCESS waits forever.
module mem_stage_module #(
  parameter int ADDR_OFFSET    = 1024,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_Rm_in,
  input  logic [3:0]  dest_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        freeze_out,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out,
  output logic [31:0] MEM_wb_value,
  output logic        wb_en_hazard,
  output logic [3:0]  dest_hazard,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [31:0] rd_latch;
  logic [31:0] off_addr;
  logic [31:0] load_data;
  logic        access;
  logic        freeze;
  logic        tmo_hit;

  assign access   = mem_r_en_in | mem_w_en_in;
  assign off_addr = alu_res_in - 32'(ADDR_OFFSET);
  assign mem_addr = {2'b00, off_addr[31:2]};

  // Gating with rst drops the request and the stall the instant reset is
  // asserted, rather than waiting for the async state reset to propagate.
  assign freeze     = rst & (((state == IDLE) & access) | (state == ACCESS));
  assign freeze_out = freeze;
  assign mem_req    = freeze;
  assign mem_we     = freeze & mem_w_en_in;
  assign mem_wdata  = val_Rm_in;

  assign MEM_wb_value = alu_res_in;
  assign wb_en_hazard = wb_en_in;
  assign dest_hazard  = dest_in;

  // A store (including read+write, where the write wins) returns no data.
  assign load_data = ((state == DONE) && mem_r_en_in && !mem_w_en_in) ? rd_latch : 32'h0;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = (state == ACCESS) && !mem_ready && (tmo_cnt == CNT_LAST);

  // Count consecutive not-ready ACCESS cycles; the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      mem_err <= 1'b0;
    end else if ((state == ACCESS) && !mem_ready) begin
      if (tmo_hit) begin
        tmo_cnt <= '0;
        mem_err <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Access sequencer: one request per instruction, DONE is a one-cycle release slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rd_latch <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (access) state <= ACCESS;
        end
        ACCESS: begin
          if (mem_ready) begin
            rd_latch <= mem_rdata;
            state    <= DONE;
          end else if (tmo_hit) begin
            rd_latch <= 32'hDEADBEEF;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register: advances whenever the pipeline is not frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      alu_res_out  <= 32'h0;
      mem_data_out <= 32'h0;
      dest_out     <= 4'h0;
    end else if (!freeze) begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      alu_res_out  <= alu_res_in;
      mem_data_out <= load_data;
      dest_out     <= dest_in;
    end
  end

endmodule

// File: tb/tb_mem_stage_module.sv
// Scoreboard bench for mem_stage_module: each transaction pushes its expected
// MEM/WB contents; a monitor pops and compares on every MEM/WB load.
module tb_mem_stage_module;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_Rm_in;
  logic [3:0]  dest_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        freeze_out;
  logic        wb_en_out, mem_r_en_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0]  dest_out;
  logic [31:0] MEM_wb_value;
  logic        wb_en_hazard;
  logic [3:0]  dest_hazard;
  logic        mem_err;

  mem_stage_module #(.ADDR_OFFSET(1024), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in), .dest_in(dest_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .freeze_out(freeze_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
    .mem_data_out(mem_data_out), .dest_out(dest_out), .MEM_wb_value(MEM_wb_value),
    .wb_en_hazard(wb_en_hazard), .dest_hazard(dest_hazard), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic        r;
    logic [31:0] alu;
    logic [31:0] data;
    logic [3:0]  dest;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: every MEM/WB load with an outstanding expectation is compared.
  exp_t mon_e;
  always @(posedge clk) begin
    if (rst && !freeze_out && sb.size() > 0) begin
      mon_e = sb.pop_front();
      #1;
      check_val("wb_en_out",    32'(wb_en_out),    32'(mon_e.wb));
      check_val("mem_r_en_out", 32'(mem_r_en_out), 32'(mon_e.r));
      check_val("alu_res_out",  alu_res_out,       mon_e.alu);
      check_val("mem_data_out", mem_data_out,      mon_e.data);
      check_val("dest_out",     32'(dest_out),     32'(mon_e.dest));
    end
  end

  task automatic drive_idle();
    wb_en_in    = 1'b0;
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
    alu_res_in  = 32'h0;
    val_Rm_in   = 32'h0;
    dest_in     = 4'h0;
    mem_rdata   = 32'h0;
    mem_ready   = 1'b0;
  endtask

  // Present one instruction, play the memory (ready in ACCESS cycle wait_n+1),
  // and check the stall length plus the combinational taps.
  task automatic issue(input string tag, input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] rm, input logic [31:0] rdata,
                       input logic [3:0] dest, input int wait_n, input int exp_fz,
                       input logic [31:0] exp_data, input logic [31:0] exp_addr);
    exp_t e;
    int   fz;
    bit   done;
    fz   = 0;
    done = 1'b0;
    @(negedge clk);
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = alu; val_Rm_in = rm; dest_in = dest;
    mem_rdata = rdata; mem_ready = 1'b0;
    e.wb = wb; e.r = r; e.alu = alu; e.data = exp_data; e.dest = dest;
    sb.push_back(e);
    #1;
    check_val({tag, " MEM_wb_value"}, MEM_wb_value, alu);
    check_val({tag, " dest_hazard"}, 32'(dest_hazard), 32'(dest));
    check_val({tag, " wb_en_hazard"}, 32'(wb_en_hazard), 32'(wb));
    if (r | w) begin
      check_val({tag, " mem_addr"}, mem_addr, exp_addr);
      check_val({tag, " mem_wdata"}, mem_wdata, rm);
      check_val({tag, " mem_we"}, 32'(mem_we), 32'(w));
      check_val({tag, " mem_req"}, 32'(mem_req), 32'd1);
    end
    for (int c = 0; c < 200 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (freeze_out) begin
        fz++;
        mem_ready = (c == wait_n + 1);
      end else begin
        if (r | w) check_val({tag, " req_in_done"}, 32'(mem_req), 32'd0);
        mem_ready = 1'b0;
        done = 1'b1;
      end
    end
    check_val({tag, " load_seen"}, 32'(done), 32'd1);
    check_val({tag, " freeze_cycles"}, 32'(fz), 32'(exp_fz));
    @(posedge clk);
    #2;
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    rst = 1'b0;
    mem_r_en_in = 1'b1;
    #12;
    check_val("rst mem_req", 32'(mem_req), 32'd0);
    check_val("rst freeze_out", 32'(freeze_out), 32'd0);
    check_val("rst alu_res_out", alu_res_out, 32'h0);
    check_val("rst mem_data_out", mem_data_out, 32'h0);
    check_val("rst mem_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;

    issue("noacc", 1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 32'h0, 4'd3, 0, 0, 32'h0, 32'h0);
    issue("load", 1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 32'hCAFE0001, 4'd5, 0, 2, 32'hCAFE0001, 32'd2);
    issue("store", 1'b0, 1'b0, 1'b1, 32'd1028, 32'h12345678, 32'h0, 4'd6, 3, 5, 32'h0, 32'd1);
    issue("rw", 1'b1, 1'b1, 1'b1, 32'd1036, 32'h0BADF00D, 32'hA5A5A5A5, 4'd7, 1, 3, 32'h0, 32'd3);
    issue("b2b_a", 1'b1, 1'b1, 1'b0, 32'd2048, 32'h0, 32'h11111111, 4'd8, 0, 2, 32'h11111111, 32'd256);
    issue("b2b_b", 1'b1, 1'b1, 1'b0, 32'd4096, 32'h0, 32'h22222222, 4'd9, 2, 4, 32'h22222222, 32'd768);
    issue("low_addr", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0F0F0F0F, 4'd10, 0, 2, 32'h0F0F0F0F, 32'h3FFFFF00);
`ifdef MEM_TIMEOUT_EN
    issue("timeout", 1'b1, 1'b1, 1'b0, 32'd1100, 32'h0, 32'h77777777, 4'd11, 1000, 16, 32'hDEADBEEF, 32'd19);
    check_val("timeout mem_err", 32'(mem_err), 32'd1);
    issue("after_to", 1'b1, 1'b0, 1'b0, 32'h66, 32'h0, 32'h0, 4'd12, 0, 0, 32'h0, 32'h0);
    check_val("sticky mem_err", 32'(mem_err), 32'd1);
`else
    issue("long_wait", 1'b1, 1'b1, 1'b0, 32'd1100, 32'h0, 32'h77777777, 4'd11, 20, 22, 32'h77777777, 32'd19);
    check_val("no_tmo mem_err", 32'(mem_err), 32'd0);
`endif

    // Reset in the middle of an access: outputs clear at once, no load survives.
    @(negedge clk);
    wb_en_in = 1'b1; mem_r_en_in = 1'b1; alu_res_in = 32'd1040; dest_in = 4'd13;
    mem_rdata = 32'h99999999; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_val("pre_rst freeze_out", 32'(freeze_out), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("abort mem_req", 32'(mem_req), 32'd0);
    check_val("abort freeze_out", 32'(freeze_out), 32'd0);
    check_val("abort wb_en_out", 32'(wb_en_out), 32'd0);
    check_val("abort alu_res_out", alu_res_out, 32'h0);
    check_val("abort mem_data_out", mem_data_out, 32'h0);
    check_val("abort dest_out", 32'(dest_out), 32'd0);
    check_val("abort mem_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst alu_res_out", alu_res_out, 32'h0);
    check_val("post_rst mem_data_out", mem_data_out, 32'h0);
    issue("post_rst", 1'b1, 1'b0, 1'b0, 32'hABCD, 32'h0, 32'h0, 4'd14, 0, 0, 32'h0, 32'h0);
    issue("post_rst_ld", 1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 32'h31415926, 4'd15, 0, 2, 32'h31415926, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
